// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port A has fixed priority, port B is force-granted
// after STARVE_LIMIT consecutive denied cycles. Responses are registered one cycle after the grant.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DEPTH        = 2048
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_ack,
    output logic        a_err,
    output logic [31:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] b_rdata,

    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteVal,
    input  logic [31:0] Out
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    localparam logic [31:0]   DEPTH_W = 32'(DEPTH);

    logic [CW-1:0] wait_cnt;
    logic          force_b;
    logic          a_in_range;
    logic          b_in_range;

    assign force_b    = (wait_cnt == LIMIT);
    assign a_in_range = (a_addr < DEPTH_W);
    assign b_in_range = (b_addr < DEPTH_W);

    // Grants are held low during reset so no strobe (and no write) can escape.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            a_gnt = a_req & ~force_b;
            b_gnt = b_req & (~a_req | force_b);
        end
    end

    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Address  = '0;
        WriteVal = '0;
        if (a_gnt) begin
            Address  = a_addr;
            WriteVal = a_wdata;
            MemRead  = ~a_we & a_in_range;
            MemWrite =  a_we & a_in_range;
        end else if (b_gnt) begin
            Address  = b_addr;
            WriteVal = b_wdata;
            MemRead  = ~b_we & b_in_range;
            MemWrite =  b_we & b_in_range;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (b_req && !b_gnt) begin
            if (wait_cnt != LIMIT)
                wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Non-granted port keeps its last err/rdata; only its ack drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ack   <= 1'b0;
            a_err   <= 1'b0;
            a_rdata <= '0;
        end else if (a_gnt) begin
            a_ack   <= 1'b1;
            a_err   <= ~a_in_range;
            a_rdata <= (a_in_range && !a_we) ? Out : '0;
        end else begin
            a_ack   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_ack   <= 1'b0;
            b_err   <= 1'b0;
            b_rdata <= '0;
        end else if (b_gnt) begin
            b_ack   <= 1'b1;
            b_err   <= ~b_in_range;
            b_rdata <= (b_in_range && !b_we) ? Out : '0;
        end else begin
            b_ack   <= 1'b0;
        end
    end

endmodule
